// File: rtl/imul_mac_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imul_mac_stage
//  Description : Two-stage valid/ready wrapper around an external
//                combinational WIDTHxWIDTH multiplier. Stage 1 registers the
//                operand pair and drives the multiplier. Stage 2 captures the
//                returned product and can accumulate it into a 2*WIDTH-bit
//                running sum with a sticky carry-out flag.
//  Revision    : 1.0  initial release
// ============================================================================
module imul_mac_stage #(
    parameter int WIDTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iValid,
    output logic               oReady,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    input  logic               iAcc,
    input  logic               iClr,
    output logic [WIDTH-1:0]   oMulA,
    output logic [WIDTH-1:0]   oMulB,
    input  logic [2*WIDTH-1:0] iMulP,
    output logic               oValid,
    input  logic               iReady,
    output logic [2*WIDTH-1:0] oResult,
    output logic               oOvf
);

    localparam int c_PW = 2 * WIDTH;

    // Stage 1 state
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_acc1;
    logic             r_clr1;
    logic             r_v1;

    // Stage 2 state
    logic [c_PW-1:0]  r_result;
    logic             r_ovf;
    logic             r_v2;
    logic [c_PW-1:0]  r_acc;
    logic             r_sticky;

    logic             w_s2_free;
    logic             w_accept;
    logic             w_xfer;
    logic [c_PW:0]    w_sum;

    // Handshake decode: stage 2 can take data when empty or being drained;
    // stage 1 can take data when empty or when it is moving into stage 2.
    always_comb begin
        w_s2_free = !r_v2 || iReady;
        oReady    = !r_v1 || w_s2_free;
        w_accept  = iValid && oReady;
        w_xfer    = r_v1 && w_s2_free;
        w_sum     = {1'b0, r_acc} + {1'b0, iMulP};
    end

    // Stage 1: operand register; holds its contents while stalled.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc1 <= 1'b0;
            r_clr1 <= 1'b0;
            r_v1   <= 1'b0;
        end else if (w_accept) begin
            r_a    <= iA;
            r_b    <= iB;
            r_acc1 <= iAcc;
            r_clr1 <= iClr;
            r_v1   <= 1'b1;
        end else if (w_xfer) begin
            r_v1   <= 1'b0;
        end
    end

    // Stage 2: result capture plus accumulator and sticky overflow update.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_v2     <= 1'b0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else if (w_xfer) begin
            r_v2 <= 1'b1;
            if (!r_acc1) begin
                // Plain multiply leaves the running sum untouched.
                r_result <= iMulP;
                r_ovf    <= 1'b0;
            end else if (r_clr1) begin
                r_acc    <= iMulP;
                r_sticky <= 1'b0;
                r_result <= iMulP;
                r_ovf    <= 1'b0;
            end else begin
                r_acc    <= w_sum[c_PW-1:0];
                r_sticky <= r_sticky | w_sum[c_PW];
                r_result <= w_sum[c_PW-1:0];
                r_ovf    <= r_sticky | w_sum[c_PW];
            end
        end else if (iReady) begin
            r_v2 <= 1'b0;
        end
    end

    assign oMulA   = r_a;
    assign oMulB   = r_b;
    assign oValid  = r_v2;
    assign oResult = r_result;
    assign oOvf    = r_ovf;

endmodule
`default_nettype wire
